ldp_ring_reader: RTL and testbench
==================================

// Module: ldp_ring_reader
// PURPOSE
//  Consumer side of the LDP frame/metadata ring protocol. Tracks the producer's frame-counter writes to FC_ADDR.
//  For each new frame, issues read commands for the frame-data slots (FD0, FD1) and metadata slots (MD0, MD1).
//  Waits for their completions, then advances its ring pointers and the consumed-frame count.
//  Sits between the LDP manager's FC-write tap and a read DMA engine.
// PARAMETERS
//  MD_ENTRY_SIZE  64   bytes of metadata per frame in each MD ring
//  AW             64   address width
// PORTS
//  clk            in   1    system clock
//  resetn         in   1    asynchronous active-low reset
//  enable         in   1    1=run; rising edge latches config and clears pointers
//  FRAME_SIZE     in   32   bytes per frame-data slot
//  FD0_RING_ADDR  in   AW   base of frame-data ring 0
//  FD1_RING_ADDR  in   AW   base of frame-data ring 1
//  FD_RING_SIZE   in   AW   bytes in each FD ring
//  MD0_RING_ADDR  in   AW   base of metadata ring 0
//  MD1_RING_ADDR  in   AW   base of metadata ring 1
//  MD_RING_SIZE   in   AW   bytes in each MD ring
//  fc_valid       in   1    producer wrote frame counter this cycle
//  fc_data        in   32   absolute frames-produced count
//  cmd_valid      out  1    read command valid
//  cmd_ready      in   1    read engine accepts command
//  cmd_addr       out  AW   read start address
//  cmd_len        out  32   read length, bytes
//  cmd_id         out  2    0=FD0 1=FD1 2=MD0 3=MD1
//  rsp_done       in   1    one pulse per completed command, in order
//  consumed       out  32   frames fully consumed
//  overrun        out  1    sticky: producer lapped the FD ring
//  busy           out  1    state != IDLE
// BEHAVIOUR
//  - Reset: cmd_valid=0, cmd_addr=0, cmd_len=0, cmd_id=0, consumed=0, overrun=0, busy=0.
//    Internal: produced=0, fd_off=0, md_off=0, state=IDLE.
//  - Config is latched on the enable rising edge; inputs are ignored otherwise.
//    The same edge clears produced, consumed, fd_off, md_off and overrun.
//    fd_cap = FD_RING_SIZE/FRAME_SIZE, computed once in the LOAD state.
//  - fc_valid: produced <= fc_data, in any state including mid-frame.
//  - Overrun: set when (produced - consumed) > fd_cap. Checked every cycle.
//    Uses 32-bit modulo subtraction, so the counter may wrap past 2^32.
//  - FSM:
//    - IDLE:    enable && (produced != consumed) -> ISSUE with idx=0.
//    - ISSUE:   cmd_valid=1. addr/len/id come from idx (FD: base+fd_off, FRAME_SIZE; MD: base+md_off, MD_ENTRY_SIZE).
//               On cmd_valid&&cmd_ready: idx++. idx==3 accepted -> WAIT.
//               cmd_* is held stable while valid && !ready.
//    - WAIT:    count rsp_done pulses; 4th pulse -> ADVANCE.
//               rsp_done seen during ISSUE is counted too.
//    - ADVANCE: one cycle. consumed++.
//               fd_off += FRAME_SIZE, but 0 if fd_off+2*FRAME_SIZE > FD_RING_SIZE.
//               md_off += MD_ENTRY_SIZE, but 0 if md_off+2*MD_ENTRY_SIZE > MD_RING_SIZE.
//               Then -> IDLE.
//  - enable deasserted mid-frame: the current frame completes (no dropped responses); the FSM then parks in IDLE.
//  - fc_data < consumed (producer reset): treated via modulo difference.
//    Software must re-pulse enable.
//  - Latency: fc_valid -> first cmd_valid = 2 cycles from IDLE.
//  - Widths: offset adds are AW-bit. FRAME_SIZE=0 is illegal and is not checked.
// STRUCTURE
//  - ldp_pkg holds: state enum, cmd_id constants (CMD_FD0..CMD_MD1), MD_ENTRY_SIZE default.
//  - Sub-module ring_ptr (base, size, step -> addr, advance pulse) is instantiated twice (FD, MD).
//  - FSM and counters live in the top module.
// TESTING
//  1. Defaults (FRAME 0x10000, FD size 0x40000, MD size 0x1000), fc_data=1, cmd_ready=1
//     -> cmds 0x1000_0000, 0x2000_0000, 0x3000_0000, 0x4000_0000; 4 rsp_done -> consumed=1.
//  2. fc_data=5, sequential consumption -> frame 4 FD0 addr=0x1000_0000 (wrap after 0x1003_0000);
//     MD0 addr=0x3000_0100.
//  3. cmd_ready low 3 cycles during ISSUE -> cmd_addr/len/id stable; no command is skipped.
//  4. fc_data jumps 0->5 with FD ring of 4 slots -> overrun=1 next cycle, remains 1 until enable re-edge.
//  5. resetn low mid-WAIT -> all outputs at reset values asynchronously; after release, idle until fc_valid.
//  6. enable dropped after 2nd cmd accepted -> remaining 2 cmds issued, consumed=1, then IDLE despite produced=3.

Source files
------------

// File: rtl/ldp_pkg.sv
// Shared types and constants for the LDP consumer-side ring reader.
package ldp_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_ADVANCE
    } state_t;

    localparam logic [1:0] CMD_FD0 = 2'd0;
    localparam logic [1:0] CMD_FD1 = 2'd1;
    localparam logic [1:0] CMD_MD0 = 2'd2;
    localparam logic [1:0] CMD_MD1 = 2'd3;

    localparam int unsigned LDP_MD_ENTRY_SIZE = 64;

endpackage

// File: rtl/ring_ptr.sv
// Ring offset tracker: addr = base + offset. The offset steps on advance and wraps to 0
// once another two steps would no longer fit inside the ring.
module ring_ptr #(
    parameter int unsigned AW = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          clear,
    input  logic          advance,
    input  logic [AW-1:0] base,
    input  logic [AW-1:0] size,
    input  logic [AW-1:0] step,
    output logic [AW-1:0] addr
);

    logic [AW-1:0] off;

    // NOTE: non-blocking assignment so every flop samples pre-edge values; blocking here would race other always_ff readers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            off <= '0;
        end else if (clear) begin
            off <= '0;
        end else if (advance) begin
            off <= (off + (step << 1) > size) ? '0 : off + step;
        end
    end

    assign addr = base + off;

endmodule

// File: rtl/ldp_ring_reader.sv
// Consumer of the LDP frame/metadata rings: follows frame-counter writes, issues the four
// slot reads per frame, waits for their completions and advances the ring pointers.
module ldp_ring_reader
    import ldp_pkg::*;
#(
    parameter int unsigned MD_ENTRY_SIZE = LDP_MD_ENTRY_SIZE,
    parameter int unsigned AW            = 64
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          enable,
    input  logic [31:0]   FRAME_SIZE,
    input  logic [AW-1:0] FD0_RING_ADDR,
    input  logic [AW-1:0] FD1_RING_ADDR,
    input  logic [AW-1:0] FD_RING_SIZE,
    input  logic [AW-1:0] MD0_RING_ADDR,
    input  logic [AW-1:0] MD1_RING_ADDR,
    input  logic [AW-1:0] MD_RING_SIZE,
    input  logic          fc_valid,
    input  logic [31:0]   fc_data,
    output logic          cmd_valid,
    input  logic          cmd_ready,
    output logic [AW-1:0] cmd_addr,
    output logic [31:0]   cmd_len,
    output logic [1:0]    cmd_id,
    input  logic          rsp_done,
    output logic [31:0]   consumed,
    output logic          overrun,
    output logic          busy
);

    state_t        state;
    logic          enable_q;
    logic          load_req;
    logic [31:0]   frame_size_q;
    logic [AW-1:0] fd0_q, fd1_q, fd_size_q, md0_q, md1_q, md_size_q;
    logic [AW-1:0] fd_cap;
    logic [31:0]   produced;
    logic [1:0]    idx;
    logic [2:0]    rsp_cnt;

    logic          en_rise, do_load, accept, advance;
    logic [1:0]    nxt_id;
    logic [31:0]   backlog;
    logic [AW-1:0] fd_addr, md_addr;

    // An enable edge seen mid-frame is held until IDLE so in-flight responses are never orphaned.
    assign en_rise = enable & ~enable_q;
    assign do_load = (state == S_IDLE) && (en_rise || load_req);
    assign accept  = cmd_valid && cmd_ready;
    assign advance = (state == S_ADVANCE);
    assign nxt_id  = (state == S_ISSUE) ? idx + 2'd1 : CMD_FD0;
    assign backlog = produced - consumed;
    assign busy    = (state != S_IDLE);

    ring_ptr #(.AW(AW)) u_fd_ptr (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (do_load),
        .advance (advance),
        .base    (nxt_id[0] ? fd1_q : fd0_q),
        .size    (fd_size_q),
        .step    (AW'(frame_size_q)),
        .addr    (fd_addr)
    );

    ring_ptr #(.AW(AW)) u_md_ptr (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (do_load),
        .advance (advance),
        .base    (nxt_id[0] ? md1_q : md0_q),
        .size    (md_size_q),
        .step    (AW'(MD_ENTRY_SIZE)),
        .addr    (md_addr)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            enable_q     <= 1'b0;
            load_req     <= 1'b0;
            frame_size_q <= '0;
            fd0_q        <= '0;
            fd1_q        <= '0;
            fd_size_q    <= '0;
            md0_q        <= '0;
            md1_q        <= '0;
            md_size_q    <= '0;
            fd_cap       <= '1;
            produced     <= '0;
            consumed     <= '0;
            overrun      <= 1'b0;
            idx          <= '0;
            rsp_cnt      <= '0;
            cmd_valid    <= 1'b0;
            cmd_addr     <= '0;
            cmd_len      <= '0;
            cmd_id       <= CMD_FD0;
        end else begin
            enable_q <= enable;
            if (en_rise && state != S_IDLE) load_req <= 1'b1;

            if (do_load) begin
                load_req     <= 1'b0;
                frame_size_q <= FRAME_SIZE;
                fd0_q        <= FD0_RING_ADDR;
                fd1_q        <= FD1_RING_ADDR;
                fd_size_q    <= FD_RING_SIZE;
                md0_q        <= MD0_RING_ADDR;
                md1_q        <= MD1_RING_ADDR;
                md_size_q    <= MD_RING_SIZE;
                consumed     <= '0;
                overrun      <= 1'b0;
            end else if (AW'(backlog) > fd_cap) begin
                overrun <= 1'b1;
            end

            // A producer write landing on the load edge is kept rather than cleared.
            if (fc_valid)     produced <= fc_data;
            else if (do_load) produced <= '0;

            case (state)
                S_IDLE: begin
                    if (do_load) begin
                        state <= S_LOAD;
                    end else if (enable && produced != consumed) begin
                        state     <= S_ISSUE;
                        idx       <= '0;
                        rsp_cnt   <= '0;
                        cmd_valid <= 1'b1;
                        cmd_addr  <= fd_addr;
                        cmd_len   <= frame_size_q;
                        cmd_id    <= CMD_FD0;
                    end
                end
                S_LOAD: begin
                    fd_cap <= fd_size_q / AW'(frame_size_q);
                    state  <= S_IDLE;
                end
                S_ISSUE: begin
                    if (rsp_done) rsp_cnt <= rsp_cnt + 3'd1;
                    if (accept) begin
                        if (idx == CMD_MD1) begin
                            cmd_valid <= 1'b0;
                            state     <= S_WAIT;
                        end else begin
                            idx      <= nxt_id;
                            cmd_addr <= nxt_id[1] ? md_addr : fd_addr;
                            cmd_len  <= nxt_id[1] ? 32'(MD_ENTRY_SIZE) : frame_size_q;
                            cmd_id   <= nxt_id;
                        end
                    end
                end
                S_WAIT: begin
                    if (rsp_done) begin
                        if (rsp_cnt == 3'd3) state <= S_ADVANCE;
                        else                 rsp_cnt <= rsp_cnt + 3'd1;
                    end
                end
                S_ADVANCE: begin
                    consumed <= consumed + 32'd1;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ldp_ring_reader.sv
// Directed bench for ldp_ring_reader: command sequencing, ring wrap, stalls, overrun,
// enable drop and asynchronous reset.
module tb_ldp_ring_reader;

    logic        clk = 1'b0;
    logic        resetn;
    logic        enable;
    logic [31:0] FRAME_SIZE;
    logic [63:0] FD0_RING_ADDR, FD1_RING_ADDR, FD_RING_SIZE;
    logic [63:0] MD0_RING_ADDR, MD1_RING_ADDR, MD_RING_SIZE;
    logic        fc_valid;
    logic [31:0] fc_data;
    logic        cmd_valid, cmd_ready;
    logic [63:0] cmd_addr;
    logic [31:0] cmd_len;
    logic [1:0]  cmd_id;
    logic        rsp_done;
    logic [31:0] consumed;
    logic        overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] cap_addr [4];
    logic [31:0] cap_len  [4];
    logic [1:0]  cap_id   [4];
    int          cap_n;

    ldp_ring_reader dut (
        .clk           (clk),
        .resetn        (resetn),
        .enable        (enable),
        .FRAME_SIZE    (FRAME_SIZE),
        .FD0_RING_ADDR (FD0_RING_ADDR),
        .FD1_RING_ADDR (FD1_RING_ADDR),
        .FD_RING_SIZE  (FD_RING_SIZE),
        .MD0_RING_ADDR (MD0_RING_ADDR),
        .MD1_RING_ADDR (MD1_RING_ADDR),
        .MD_RING_SIZE  (MD_RING_SIZE),
        .fc_valid      (fc_valid),
        .fc_data       (fc_data),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_addr      (cmd_addr),
        .cmd_len       (cmd_len),
        .cmd_id        (cmd_id),
        .rsp_done      (rsp_done),
        .consumed      (consumed),
        .overrun       (overrun),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    // Stimulus helpers; all are entered and left on a falling edge.
    task automatic collect_cmds(input int n);
        cmd_ready = 1'b1;
        cap_n = 0;
        for (int c = 0; c < 60; c++) begin
            if (cmd_valid && cap_n < n) begin
                cap_addr[cap_n] = cmd_addr;
                cap_len[cap_n]  = cmd_len;
                cap_id[cap_n]   = cmd_id;
                cap_n++;
            end
            if (cap_n == n) break;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic send_rsp(input int n);
        for (int i = 0; i < n; i++) begin
            rsp_done = 1'b1;
            @(negedge clk);
        end
        rsp_done = 1'b0;
    endtask

    task automatic write_fc(input logic [31:0] val);
        fc_valid = 1'b1;
        fc_data  = val;
        @(negedge clk);
        fc_valid = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({cmd_valid, overrun, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {cmd_valid, overrun, busy});
        end
        n_checks++;
        if (cmd_addr !== 64'd0 || cmd_len !== 32'd0 || cmd_id !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cmd: got addr=%h len=%h id=%0d expected zeros", cmd_addr, cmd_len, cmd_id);
        end
        n_checks++;
        if (consumed !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_consumed: got %0d expected 0", consumed);
        end
        resetn = 1'b1;
        enable = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_first_frame;
        logic [63:0] exp_addr [4] = '{64'h1000_0000, 64'h2000_0000, 64'h3000_0000, 64'h4000_0000};
        logic [31:0] exp_len  [4] = '{32'h1_0000, 32'h1_0000, 32'd64, 32'd64};
        cmd_ready = 1'b0;
        write_fc(32'd1);
        n_checks++;
        if (cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL latency_early: cmd_valid got %b expected 0 one cycle after fc_valid", cmd_valid);
        end
        @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL latency: cmd_valid got %b expected 1 two cycles after fc_valid", cmd_valid);
        end
        collect_cmds(4);
        n_checks++;
        if (cap_n !== 4) begin
            n_fail++;
            $display("FAIL first_count: got %0d commands expected 4", cap_n);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_addr[i] !== exp_addr[i] || cap_len[i] !== exp_len[i] || cap_id[i] !== 2'(i)) begin
                n_fail++;
                $display("FAIL first_cmd%0d: got addr=%h len=%h id=%0d expected addr=%h len=%h id=%0d",
                         i, cap_addr[i], cap_len[i], cap_id[i], exp_addr[i], exp_len[i], i);
            end
        end
        send_rsp(4);
        repeat (2) @(negedge clk);
        n_checks++;
        if (consumed !== 32'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL first_done: got consumed=%0d busy=%b expected 1 0", consumed, busy);
        end
    endtask

    task automatic test_ring_wrap;
        logic [63:0] exp_fd0 [4] = '{64'h1001_0000, 64'h1002_0000, 64'h1003_0000, 64'h1000_0000};
        logic [63:0] exp_md1 [4] = '{64'h4000_0040, 64'h4000_0080, 64'h4000_00C0, 64'h4000_0100};
        write_fc(32'd5);
        for (int k = 0; k < 4; k++) begin
            collect_cmds(4);
            n_checks++;
            if (cap_n !== 4 || cap_addr[0] !== exp_fd0[k] || cap_addr[3] !== exp_md1[k]) begin
                n_fail++;
                $display("FAIL wrap_frame%0d: got n=%0d fd0=%h md1=%h expected n=4 fd0=%h md1=%h",
                         k + 1, cap_n, cap_addr[0], cap_addr[3], exp_fd0[k], exp_md1[k]);
            end
            send_rsp(4);
        end
        n_checks++;
        if (cap_addr[2] !== 64'h3000_0100) begin
            n_fail++;
            $display("FAIL wrap_md0: got %h expected 30000100", cap_addr[2]);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (consumed !== 32'd5 || overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL wrap_done: got consumed=%0d overrun=%b expected 5 0", consumed, overrun);
        end
    endtask

    task automatic test_stall;
        logic [63:0] exp_addr [4] = '{64'h1001_0000, 64'h2001_0000, 64'h3000_0140, 64'h4000_0140};
        int guard = 0;
        cmd_ready = 1'b0;
        write_fc(32'd6);
        while (!cmd_valid && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (cmd_valid !== 1'b1 || cmd_addr !== exp_addr[0] || cmd_len !== 32'h1_0000 || cmd_id !== 2'd0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: got v=%b addr=%h len=%h id=%0d expected 1 %h 10000 0",
                         s, cmd_valid, cmd_addr, cmd_len, cmd_id, exp_addr[0]);
            end
            @(negedge clk);
        end
        collect_cmds(4);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (cap_n !== 4 || cap_id[i] !== 2'(i) || cap_addr[i] !== exp_addr[i]) begin
                n_fail++;
                $display("FAIL stall_cmd%0d: got n=%0d id=%0d addr=%h expected n=4 id=%0d addr=%h",
                         i, cap_n, cap_id[i], cap_addr[i], i, exp_addr[i]);
            end
        end
        send_rsp(4);
        repeat (2) @(negedge clk);
        n_checks++;
        if (consumed !== 32'd6) begin
            n_fail++;
            $display("FAIL stall_done: got consumed=%0d expected 6", consumed);
        end
    endtask

    task automatic test_overrun;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (consumed !== 32'd0 || overrun !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reload: got consumed=%0d overrun=%b busy=%b expected 0 0 0", consumed, overrun, busy);
        end
        write_fc(32'd5);
        @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b expected 1", overrun);
        end
        collect_cmds(4);
        n_checks++;
        if (cap_n !== 4 || cap_addr[0] !== 64'h1000_0000) begin
            n_fail++;
            $display("FAIL overrun_ptr: got n=%0d fd0=%h expected 4 10000000", cap_n, cap_addr[0]);
        end
        enable = 1'b0;
        send_rsp(4);
        repeat (3) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b1 || consumed !== 32'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_sticky: got overrun=%b consumed=%0d busy=%b expected 1 1 0", overrun, consumed, busy);
        end
        enable = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (overrun !== 1'b0 || consumed !== 32'd0) begin
            n_fail++;
            $display("FAIL overrun_clear: got overrun=%b consumed=%0d expected 0 0", overrun, consumed);
        end
    endtask

    task automatic test_enable_drop;
        write_fc(32'd3);
        collect_cmds(2);
        enable = 1'b0;
        collect_cmds(2);
        n_checks++;
        if (cap_n !== 2 || cap_id[0] !== 2'd2 || cap_id[1] !== 2'd3 ||
            cap_addr[0] !== 64'h3000_0000 || cap_addr[1] !== 64'h4000_0000) begin
            n_fail++;
            $display("FAIL drop_tail: got n=%0d ids=%0d,%0d addrs=%h,%h expected 2 ids 2,3 30000000,40000000",
                     cap_n, cap_id[0], cap_id[1], cap_addr[0], cap_addr[1]);
        end
        send_rsp(4);
        repeat (4) @(negedge clk);
        n_checks++;
        if (consumed !== 32'd1 || busy !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_park: got consumed=%0d busy=%b cmd_valid=%b expected 1 0 0", consumed, busy, cmd_valid);
        end
    endtask

    task automatic test_reset_mid_wait;
        enable = 1'b1;
        repeat (3) @(negedge clk);
        write_fc(32'd2);
        collect_cmds(4);
        send_rsp(4);
        collect_cmds(4);
        n_checks++;
        if (cap_n !== 4 || cap_addr[0] !== 64'h1001_0000) begin
            n_fail++;
            $display("FAIL second_frame: got n=%0d fd0=%h expected 4 10010000", cap_n, cap_addr[0]);
        end
        send_rsp(2);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({cmd_valid, busy, overrun} !== 3'b000 || consumed !== 32'd0 ||
            cmd_addr !== 64'd0 || cmd_len !== 32'd0 || cmd_id !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b busy=%b ov=%b consumed=%0d addr=%h len=%h id=%0d expected all zero",
                     cmd_valid, busy, overrun, consumed, cmd_addr, cmd_len, cmd_id);
        end
        @(negedge clk);
        resetn = 1'b1;
        repeat (5) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_idle: got busy=%b cmd_valid=%b expected 0 0", busy, cmd_valid);
        end
        cmd_ready = 1'b0;
        write_fc(32'd1);
        @(negedge clk);
        n_checks++;
        if (cmd_valid !== 1'b1 || cmd_addr !== 64'h1000_0000) begin
            n_fail++;
            $display("FAIL post_reset_cmd: got v=%b addr=%h expected 1 10000000", cmd_valid, cmd_addr);
        end
        collect_cmds(4);
        send_rsp(4);
        repeat (2) @(negedge clk);
        n_checks++;
        if (consumed !== 32'd1) begin
            n_fail++;
            $display("FAIL post_reset_done: got consumed=%0d expected 1", consumed);
        end
    endtask

    initial begin
        resetn        = 1'b0;
        enable        = 1'b0;
        FRAME_SIZE    = 32'h1_0000;
        FD0_RING_ADDR = 64'h1000_0000;
        FD1_RING_ADDR = 64'h2000_0000;
        FD_RING_SIZE  = 64'h4_0000;
        MD0_RING_ADDR = 64'h3000_0000;
        MD1_RING_ADDR = 64'h4000_0000;
        MD_RING_SIZE  = 64'h1000;
        fc_valid      = 1'b0;
        fc_data       = '0;
        cmd_ready     = 1'b0;
        rsp_done      = 1'b0;
        @(negedge clk);

        test_reset();
        test_first_frame();
        test_ring_wrap();
        test_stall();
        test_overrun();
        test_enable_drop();
        test_reset_mid_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
